hazard_control_unit: RTL and testbench
======================================

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter LOAD_LAT, default 1, load-use stall cycles (1..7).
REQ-003 SHALL have parameter MD_LAT, default 4, multi-cycle mul/div EX cycles (2..31).
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have inputs memRead_ID_EX (1), rd_ID_EX (REG_AW): load in ID/EX and its destination.
REQ-007 SHALL have inputs rs1_IF_ID, rs2_IF_ID (REG_AW each): sources of the instruction in IF/ID.
REQ-008 SHALL have inputs rs1_ID_EX, rs2_ID_EX (REG_AW each): sources of the instruction in EX.
REQ-009 SHALL have inputs regWrite_EX_MEM (1), rd_EX_MEM (REG_AW), regWrite_MEM_WB (1), rd_MEM_WB (REG_AW).
REQ-010 SHALL have inputs md_start (1), mul/div entering EX; branch_taken (1), redirect resolved in EX.
REQ-011 SHALL have outputs stall (1), hold PC and IF/ID; bubble (1), zero ID/EX controls; ex_hold (1), freeze ID/EX and EX.
REQ-012 SHALL have outputs flush (1), clear IF/ID and ID/EX; fwdA, fwdB (2 each), forwarding selects; md_busy (1).

Function
REQ-013 SHALL define load_use = memRead_ID_EX & rd_ID_EX!=0 & (rd_ID_EX==rs1_IF_ID | rd_ID_EX==rs2_IF_ID).
REQ-014 SHALL implement FSM states IDLE, LOAD_WAIT, MD_BUSY with a 5-bit down-counter cnt.
REQ-015 SHALL, in IDLE with load_use, assert stall=bubble=1 combinationally; if LOAD_LAT>1, go to LOAD_WAIT with cnt=LOAD_LAT-2.
REQ-016 SHALL, in LOAD_WAIT, assert stall=bubble=1; cnt!=0 decrements; cnt==0 returns to IDLE next edge.
REQ-017 SHALL, in IDLE with md_start, go to MD_BUSY with cnt=MD_LAT-2 and assert stall=ex_hold=md_busy=1 that same cycle.
REQ-018 SHALL, in MD_BUSY, assert stall=ex_hold=md_busy=1; cnt==0 returns to IDLE; the op thus occupies EX exactly MD_LAT cycles.
REQ-019 SHALL, on branch_taken, assert flush=1 that cycle, force stall=bubble=0, and return to IDLE next edge (flush wins over load_use).
REQ-020 SHALL ignore branch_taken while in MD_BUSY (branch cannot be in EX); md_start has priority over load_use in IDLE.
REQ-021 SHALL encode fwdA: 2'b10 if regWrite_EX_MEM & rd_EX_MEM!=0 & rd_EX_MEM==rs1_ID_EX; else 2'b01 if same for MEM_WB; else 2'b00.
REQ-022 SHALL encode fwdB identically against rs2_ID_EX; EX/MEM always wins over MEM/WB.
REQ-023 SHALL keep fwdA/fwdB purely combinational, zero latency, independent of FSM state.
REQ-024 SHALL never drive flush and stall high in the same cycle.

Reset
REQ-025 SHALL, while reset==0, force state=IDLE, cnt=0, and all outputs to 0 asynchronously.
REQ-026 SHALL abort any LOAD_WAIT/MD_BUSY on reset assertion mid-operation; first post-reset edge starts from IDLE.

Structure
REQ-027 SHALL take FSM state encoding, FWD_NONE/FWD_WB/FWD_MEM constants and REG_AW default from shared package riscv_pipe_pkg.
REQ-028 SHALL instantiate sub-module fwd_select twice (operand A and B), parametrised by REG_AW.

Verification
REQ-029 SHALL test load x5 in ID/EX, rs2_IF_ID=5, LOAD_LAT=1 -> stall=bubble=1 exactly one cycle; rd=0 case -> no stall.
REQ-030 SHALL test LOAD_LAT=3, load-use -> stall=1 three consecutive cycles, then 0.
REQ-031 SHALL test md_start, MD_LAT=4 -> md_busy/ex_hold/stall=1 four cycles; branch_taken during it ignored.
REQ-032 SHALL test rd_EX_MEM=rd_MEM_WB=7, both regWrite, rs1_ID_EX=7 -> fwdA=2'b10; EX/MEM regWrite=0 -> 2'b01.
REQ-033 SHALL test branch_taken with load_use same cycle -> flush=1, stall=0; reset low in MD_BUSY cycle 2 -> all outputs 0, IDLE.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types and constants for the hazard/forwarding logic.
// Imported by the hazard control unit and its forwarding selectors.
package riscv_pipe_pkg;

  localparam int REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    MD_BUSY   = 2'd2
  } hz_state_t;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

endpackage

// File: rtl/fwd_select.sv
// Operand forwarding select for one EX source register.
// The youngest producer (EX/MEM) beats the older one (MEM/WB).
module fwd_select
  import riscv_pipe_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              wr_mem,
  input  logic [REG_AW-1:0] rd_mem,
  input  logic              wr_wb,
  input  logic [REG_AW-1:0] rd_wb,
  output logic [1:0]        sel
);

  logic hit_mem;
  logic hit_wb;

  assign hit_mem = wr_mem && (rd_mem != '0) && (rd_mem == rs);
  assign hit_wb  = wr_wb && (rd_wb != '0) && (rd_wb == rs);

  always_comb begin
    sel = FWD_NONE;
    if (hit_mem)
      sel = FWD_MEM;
    else if (hit_wb)
      sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: load-use and mul/div stalls, branch
// flush, and EX operand forwarding selects.
module hazard_control_unit
  import riscv_pipe_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int LOAD_LAT = 1,
  parameter int MD_LAT   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memRead_ID_EX,
  input  logic [REG_AW-1:0] rd_ID_EX,
  input  logic [REG_AW-1:0] rs1_IF_ID,
  input  logic [REG_AW-1:0] rs2_IF_ID,
  input  logic [REG_AW-1:0] rs1_ID_EX,
  input  logic [REG_AW-1:0] rs2_ID_EX,
  input  logic              regWrite_EX_MEM,
  input  logic [REG_AW-1:0] rd_EX_MEM,
  input  logic              regWrite_MEM_WB,
  input  logic [REG_AW-1:0] rd_MEM_WB,
  input  logic              md_start,
  input  logic              branch_taken,
  output logic              stall,
  output logic              bubble,
  output logic              ex_hold,
  output logic              flush,
  output logic [1:0]        fwdA,
  output logic [1:0]        fwdB,
  output logic              md_busy
);

  localparam logic [4:0] LD_CNT =
    5'((LOAD_LAT > 1) ? LOAD_LAT - 2 : 0);
  localparam logic [4:0] MD_CNT = 5'(MD_LAT - 2);

  hz_state_t  state;
  hz_state_t  nxt_state;
  logic [4:0] cnt;
  logic [4:0] nxt_cnt;

  logic load_use;
  logic stall_c;
  logic bubble_c;
  logic ex_hold_c;
  logic flush_c;
  logic busy_c;
  logic [1:0] fa;
  logic [1:0] fb;

  assign load_use = memRead_ID_EX && (rd_ID_EX != '0) &&
                    ((rd_ID_EX == rs1_IF_ID) ||
                     (rd_ID_EX == rs2_IF_ID));

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    stall_c   = 1'b0;
    bubble_c  = 1'b0;
    ex_hold_c = 1'b0;
    flush_c   = 1'b0;
    busy_c    = 1'b0;
    unique case (state)
      IDLE: begin
        if (branch_taken) begin
          flush_c = 1'b1;
        end else if (md_start) begin
          stall_c   = 1'b1;
          ex_hold_c = 1'b1;
          busy_c    = 1'b1;
          nxt_state = MD_BUSY;
          nxt_cnt   = MD_CNT;
        end else if (load_use) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          if (LOAD_LAT > 1) begin
            nxt_state = LOAD_WAIT;
            nxt_cnt   = LD_CNT;
          end
        end
      end
      LOAD_WAIT: begin
        if (branch_taken) begin
          flush_c   = 1'b1;
          nxt_state = IDLE;
          nxt_cnt   = '0;
        end else begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          if (cnt == '0)
            nxt_state = IDLE;
          else
            nxt_cnt = cnt - 5'd1;
        end
      end
      MD_BUSY: begin
        // a branch cannot be resolving while EX is held
        stall_c   = 1'b1;
        ex_hold_c = 1'b1;
        busy_c    = 1'b1;
        if (cnt == '0)
          nxt_state = IDLE;
        else
          nxt_cnt = cnt - 5'd1;
      end
      default: begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
    end
  end

  fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
    .rs     (rs1_ID_EX),
    .wr_mem (regWrite_EX_MEM),
    .rd_mem (rd_EX_MEM),
    .wr_wb  (regWrite_MEM_WB),
    .rd_wb  (rd_MEM_WB),
    .sel    (fa)
  );

  fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
    .rs     (rs2_ID_EX),
    .wr_mem (regWrite_EX_MEM),
    .rd_mem (rd_EX_MEM),
    .wr_wb  (regWrite_MEM_WB),
    .rd_wb  (rd_MEM_WB),
    .sel    (fb)
  );

  assign stall   = reset && stall_c;
  assign bubble  = reset && bubble_c;
  assign ex_hold = reset && ex_hold_c;
  assign flush   = reset && flush_c;
  assign md_busy = reset && busy_c;
  assign fwdA    = reset ? fa : FWD_NONE;
  assign fwdB    = reset ? fb : FWD_NONE;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed self-checking bench for hazard_control_unit.
// Two instances share stimulus: LOAD_LAT=1 and LOAD_LAT=3.
module tb_hazard_control_unit;

  logic       clk;
  logic       reset;
  logic       memRead_ID_EX;
  logic [4:0] rd_ID_EX;
  logic [4:0] rs1_IF_ID;
  logic [4:0] rs2_IF_ID;
  logic [4:0] rs1_ID_EX;
  logic [4:0] rs2_ID_EX;
  logic       regWrite_EX_MEM;
  logic [4:0] rd_EX_MEM;
  logic       regWrite_MEM_WB;
  logic [4:0] rd_MEM_WB;
  logic       md_start;
  logic       branch_taken;

  logic       stall1, bubble1, ex_hold1, flush1, md_busy1;
  logic [1:0] fwdA1, fwdB1;
  logic       stall3, bubble3, ex_hold3, flush3, md_busy3;
  logic [1:0] fwdA3, fwdB3;

  int checks;
  int failures;

  hazard_control_unit #(
    .REG_AW(5), .LOAD_LAT(1), .MD_LAT(4)
  ) u_dut1 (
    .clk             (clk),
    .reset           (reset),
    .memRead_ID_EX   (memRead_ID_EX),
    .rd_ID_EX        (rd_ID_EX),
    .rs1_IF_ID       (rs1_IF_ID),
    .rs2_IF_ID       (rs2_IF_ID),
    .rs1_ID_EX       (rs1_ID_EX),
    .rs2_ID_EX       (rs2_ID_EX),
    .regWrite_EX_MEM (regWrite_EX_MEM),
    .rd_EX_MEM       (rd_EX_MEM),
    .regWrite_MEM_WB (regWrite_MEM_WB),
    .rd_MEM_WB       (rd_MEM_WB),
    .md_start        (md_start),
    .branch_taken    (branch_taken),
    .stall           (stall1),
    .bubble          (bubble1),
    .ex_hold         (ex_hold1),
    .flush           (flush1),
    .fwdA            (fwdA1),
    .fwdB            (fwdB1),
    .md_busy         (md_busy1)
  );

  hazard_control_unit #(
    .REG_AW(5), .LOAD_LAT(3), .MD_LAT(4)
  ) u_dut3 (
    .clk             (clk),
    .reset           (reset),
    .memRead_ID_EX   (memRead_ID_EX),
    .rd_ID_EX        (rd_ID_EX),
    .rs1_IF_ID       (rs1_IF_ID),
    .rs2_IF_ID       (rs2_IF_ID),
    .rs1_ID_EX       (rs1_ID_EX),
    .rs2_ID_EX       (rs2_ID_EX),
    .regWrite_EX_MEM (regWrite_EX_MEM),
    .rd_EX_MEM       (rd_EX_MEM),
    .regWrite_MEM_WB (regWrite_MEM_WB),
    .rd_MEM_WB       (rd_MEM_WB),
    .md_start        (md_start),
    .branch_taken    (branch_taken),
    .stall           (stall3),
    .bubble          (bubble3),
    .ex_hold         (ex_hold3),
    .flush           (flush3),
    .fwdA            (fwdA3),
    .fwdB            (fwdB3),
    .md_busy         (md_busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    memRead_ID_EX   = 1'b0;
    rd_ID_EX        = '0;
    rs1_IF_ID       = '0;
    rs2_IF_ID       = '0;
    rs1_ID_EX       = '0;
    rs2_ID_EX       = '0;
    regWrite_EX_MEM = 1'b0;
    rd_EX_MEM       = '0;
    regWrite_MEM_WB = 1'b0;
    rd_MEM_WB       = '0;
    md_start        = 1'b0;
    branch_taken    = 1'b0;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // {stall,bubble,ex_hold,flush,md_busy} for each instance
  function automatic logic [31:0] ctl1();
    return {27'd0, stall1, bubble1, ex_hold1, flush1, md_busy1};
  endfunction

  function automatic logic [31:0] ctl3();
    return {27'd0, stall3, bubble3, ex_hold3, flush3, md_busy3};
  endfunction

  logic [3:0] exp_ld1;
  logic [3:0] exp_ld3;

  initial begin
    checks   = 0;
    failures = 0;
    clear_in();
    reset = 1'b0;

    // reset with hazardous inputs present: everything must be 0
    memRead_ID_EX   = 1'b1;
    rd_ID_EX        = 5'd5;
    rs2_IF_ID       = 5'd5;
    regWrite_EX_MEM = 1'b1;
    rd_EX_MEM       = 5'd7;
    rs1_ID_EX       = 5'd7;
    md_start        = 1'b1;
    #2;
    check("rst_ctl1", ctl1(), 32'h0);
    check("rst_ctl3", ctl3(), 32'h0);
    check("rst_fwd", {28'd0, fwdA1, fwdB1}, 32'h0);
    @(posedge clk);
    clear_in();
    @(negedge clk);
    reset = 1'b1;
    next_cyc();
    check("idle_ctl", ctl1(), 32'h0);

    // load x5, consumer reads x5 via rs2
    exp_ld1 = 4'b1000;
    exp_ld3 = 4'b1110;
    memRead_ID_EX = 1'b1;
    rd_ID_EX      = 5'd5;
    rs2_IF_ID     = 5'd5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("ld1_c%0d", i),
            {30'd0, stall1, bubble1}, {30'd0, {2{exp_ld1[3-i]}}});
      check($sformatf("ld3_c%0d", i),
            {30'd0, stall3, bubble3}, {30'd0, {2{exp_ld3[3-i]}}});
      next_cyc();
      memRead_ID_EX = 1'b0;
    end
    clear_in();

    // load to x0 never stalls
    memRead_ID_EX = 1'b1;
    rs1_IF_ID     = 5'd0;
    @(negedge clk);
    check("ld_x0_1", ctl1(), 32'h0);
    check("ld_x0_3", ctl3(), 32'h0);
    next_cyc();
    clear_in();

    // mul/div: 4 cycles busy, branch during it ignored
    md_start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("md_c%0d", i), ctl1(),
            (i < 4) ? 32'h15 : 32'h0);
      check($sformatf("md3_c%0d", i), ctl3(),
            (i < 4) ? 32'h15 : 32'h0);
      next_cyc();
      md_start     = 1'b0;
      branch_taken = (i < 2);
    end
    clear_in();

    // forwarding priority and x0 exclusion
    regWrite_EX_MEM = 1'b1;
    rd_EX_MEM       = 5'd7;
    regWrite_MEM_WB = 1'b1;
    rd_MEM_WB       = 5'd7;
    rs1_ID_EX       = 5'd7;
    rs2_ID_EX       = 5'd3;
    #1;
    check("fwdA_mem", {30'd0, fwdA1}, 32'h2);
    check("fwdB_none", {30'd0, fwdB1}, 32'h0);
    regWrite_EX_MEM = 1'b0;
    rs2_ID_EX       = 5'd7;
    #1;
    check("fwdA_wb", {30'd0, fwdA1}, 32'h1);
    check("fwdB_wb", {30'd0, fwdB3}, 32'h1);
    regWrite_EX_MEM = 1'b1;
    rd_EX_MEM       = 5'd0;
    rd_MEM_WB       = 5'd0;
    rs1_ID_EX       = 5'd0;
    #1;
    check("fwdA_x0", {30'd0, fwdA1}, 32'h0);
    rd_EX_MEM = 5'd9;
    rd_MEM_WB = 5'd9;
    rs2_ID_EX = 5'd9;
    #1;
    check("fwdB_mem", {30'd0, fwdB1}, 32'h2);
    clear_in();

    // branch beats a same-cycle load-use
    memRead_ID_EX = 1'b1;
    rd_ID_EX      = 5'd5;
    rs1_IF_ID     = 5'd5;
    branch_taken  = 1'b1;
    @(negedge clk);
    check("br_ld1", ctl1(), 32'h2);
    check("br_ld3", ctl3(), 32'h2);
    next_cyc();
    clear_in();
    @(negedge clk);
    check("br_after3", ctl3(), 32'h0);
    next_cyc();

    // branch aborts an ongoing load wait
    memRead_ID_EX = 1'b1;
    rd_ID_EX      = 5'd6;
    rs1_IF_ID     = 5'd6;
    next_cyc();
    clear_in();
    branch_taken = 1'b1;
    @(negedge clk);
    check("lw_br3", ctl3(), 32'h2);
    next_cyc();
    clear_in();
    @(negedge clk);
    check("lw_br_after3", ctl3(), 32'h0);
    next_cyc();

    // reset asserted in the second MD_BUSY cycle
    md_start = 1'b1;
    next_cyc();
    md_start = 1'b0;
    next_cyc();
    @(negedge clk);
    check("md2_busy", ctl3(), 32'h15);
    regWrite_EX_MEM = 1'b1;
    rd_EX_MEM       = 5'd4;
    rs1_ID_EX       = 5'd4;
    reset = 1'b0;
    #1;
    check("mdrst_ctl1", ctl1(), 32'h0);
    check("mdrst_ctl3", ctl3(), 32'h0);
    check("mdrst_fwd", {30'd0, fwdA1}, 32'h0);
    clear_in();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("post_rst_idle", ctl3(), 32'h0);
    next_cyc();
    @(negedge clk);
    check("post_rst_edge", ctl1(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
